// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared encodings for the pipelined CLA adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ADC = 2'b10,
      OP_SBB = 2'b11
   } cla_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Carry into bit 0; for SBB a set in_cin means "no borrow".
   function automatic logic carry_in(input cla_op_e op, input logic cin);
      logic c;
      case (op)
         OP_ADD:  c = 1'b0;
         OP_SUB:  c = 1'b1;
         default: c = cin;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_block.sv
`default_nettype none
// ============================================================================
// Module      : cla_block
// Description : Combinational SEG-bit carry-lookahead segment, BLOCK-bit groups.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_block #(
   parameter int SEG   = 16,
   parameter int BLOCK = 4
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   localparam int c_nb = SEG / BLOCK;

   logic [SEG-1:0]  w_g;
   logic [SEG-1:0]  w_p;
   logic [SEG-1:0]  w_c;
   logic [c_nb-1:0] w_gg;
   logic [c_nb-1:0] w_gp;
   logic [c_nb:0]   w_cg;

   assign w_g = a & b;
   assign w_p = a ^ b;

   always_comb begin
      logic t_c;
      logic t_p;
      w_gg = '0;
      w_gp = '0;
      w_cg = '0;
      w_c  = '0;
      t_c  = 1'b0;
      t_p  = 1'b1;
      for (int j = 0; j < c_nb; j++) begin
         w_gg[j] = 1'b0;
         w_gp[j] = 1'b1;
         for (int i = 0; i < BLOCK; i++) begin
            w_gg[j] = w_g[j*BLOCK+i] | (w_p[j*BLOCK+i] & w_gg[j]);
            w_gp[j] = w_gp[j] & w_p[j*BLOCK+i];
         end
      end
      // Group carries as flat sum-of-products over all lower groups.
      w_cg[0] = cin;
      for (int j = 0; j < c_nb; j++) begin
         t_c = 1'b0;
         t_p = 1'b1;
         for (int m = j; m >= 0; m--) begin
            t_c = t_c | (w_gg[m] & t_p);
            t_p = t_p & w_gp[m];
         end
         w_cg[j+1] = t_c | (t_p & cin);
      end
      for (int j = 0; j < c_nb; j++) begin
         w_c[j*BLOCK] = w_cg[j];
         for (int i = 1; i < BLOCK; i++) begin
            w_c[j*BLOCK+i] = w_g[j*BLOCK+i-1] | (w_p[j*BLOCK+i-1] & w_c[j*BLOCK+i-1]);
         end
      end
   end

   assign sum  = w_p ^ w_c;
   assign cout = w_cg[c_nb];

endmodule
`default_nettype wire

// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cla_addsub_pipe
// Description : Pipelined CLA add/sub with flags and valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_addsub_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int BLOCK  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [3:0]       out_flags
);

   localparam int c_seg  = WIDTH / STAGES;
   localparam int c_last = STAGES - 1;

   logic [WIDTH-1:0] w_bp;
   logic             w_c0;

   // op bit 0 selects the inverted-B forms (SUB, SBB).
   assign w_bp = in_op[0] ? ~in_b : in_b;
   assign w_c0 = carry_in(cla_op_e'(in_op), in_cin);

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         localparam int c_rem  = WIDTH - k*c_seg;
         localparam int c_done = (k+1)*c_seg;

         logic [c_rem-1:0]  w_a;
         logic [c_rem-1:0]  w_b;
         logic              w_ci;
         logic              w_v;
         logic              w_adv;
         logic [c_seg-1:0]  w_s;
         logic              w_co;
         logic [c_done-1:0] w_acc;

         cla_block #(.SEG(c_seg), .BLOCK(BLOCK)) u_blk (
            .a    (w_a[c_seg-1:0]),
            .b    (w_b[c_seg-1:0]),
            .cin  (w_ci),
            .sum  (w_s),
            .cout (w_co)
         );

         if (k == 0) begin : g_in
            assign w_a   = in_a;
            assign w_b   = w_bp;
            assign w_ci  = w_c0;
            assign w_v   = in_valid;
            assign w_acc = w_s;
         end else begin : g_reg
            logic [c_rem-1:0]   r_a;
            logic [c_rem-1:0]   r_b;
            logic               r_c;
            logic               r_v;
            logic [k*c_seg-1:0] r_lo;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_v  <= 1'b0;
                  r_a  <= '0;
                  r_b  <= '0;
                  r_c  <= 1'b0;
                  r_lo <= '0;
               end else if (g_stage[k-1].w_adv) begin
                  r_v <= g_stage[k-1].w_v;
                  if (g_stage[k-1].w_v) begin
                     r_a  <= g_stage[k-1].w_a[c_rem+c_seg-1:c_seg];
                     r_b  <= g_stage[k-1].w_b[c_rem+c_seg-1:c_seg];
                     r_c  <= g_stage[k-1].w_co;
                     r_lo <= g_stage[k-1].w_acc;
                  end
               end
            end

            assign w_a   = r_a;
            assign w_b   = r_b;
            assign w_ci  = r_c;
            assign w_v   = r_v;
            assign w_acc = {w_s, r_lo};
         end

         // w_adv: the register following this stage loads this cycle.
         if (k == STAGES-1) begin : g_tail
            assign w_adv = !out_valid || out_ready;
         end else begin : g_mid
            assign w_adv = !g_stage[k+1].w_v || g_stage[k+1].w_adv;
         end
      end
   endgenerate

   assign in_ready = g_stage[0].w_adv;

   logic [WIDTH-1:0] w_res;
   logic [3:0]       w_flags;
   logic             w_amsb;
   logic             w_bmsb;

   assign w_res  = g_stage[c_last].w_acc;
   assign w_amsb = g_stage[c_last].w_a[c_seg-1];
   assign w_bmsb = g_stage[c_last].w_b[c_seg-1];

   always_comb begin
      w_flags         = '0;
      w_flags[FLAG_N] = w_res[WIDTH-1];
      w_flags[FLAG_Z] = (w_res == '0);
      w_flags[FLAG_C] = g_stage[c_last].w_co;
      w_flags[FLAG_V] = (w_amsb == w_bmsb) && (w_res[WIDTH-1] != w_amsb);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_flags <= '0;
      end else if (g_stage[c_last].w_adv) begin
         out_valid <= g_stage[c_last].w_v;
         if (g_stage[c_last].w_v) begin
            out_sum   <= w_res;
            out_flags <= w_flags;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_addsub_pipe
// Description : Directed and model-based bench for cla_addsub_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_addsub_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   assertions = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   // Main instance: 32-bit, 2 stages
   logic        v0 = 0, ir0, ci0 = 0, ov0, or0 = 1;
   logic [31:0] a0 = 0, b0 = 0, s0;
   logic [1:0]  op0 = 0;
   logic [3:0]  f0;
   // 16-bit, 1 stage
   logic        v1 = 0, ir1, ci1 = 0, ov1, or1 = 1;
   logic [15:0] a1 = 0, b1 = 0, s1;
   logic [1:0]  op1 = 0;
   logic [3:0]  f1;
   // 64-bit, 4 stages
   logic        v4 = 0, ir4, ci4 = 0, ov4, or4 = 1;
   logic [63:0] a4 = 0, b4 = 0, s4;
   logic [1:0]  op4 = 0;
   logic [3:0]  f4;

   cla_addsub_pipe #(.WIDTH(32), .STAGES(2), .BLOCK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ir0), .in_a(a0), .in_b(b0),
      .in_op(op0), .in_cin(ci0), .out_valid(ov0), .out_ready(or0), .out_sum(s0), .out_flags(f0));
   cla_addsub_pipe #(.WIDTH(16), .STAGES(1), .BLOCK(4)) dut_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_a(a1), .in_b(b1),
      .in_op(op1), .in_cin(ci1), .out_valid(ov1), .out_ready(or1), .out_sum(s1), .out_flags(f1));
   cla_addsub_pipe #(.WIDTH(64), .STAGES(4), .BLOCK(4)) dut_s4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_a(a4), .in_b(b4),
      .in_op(op4), .in_cin(ci4), .out_valid(ov4), .out_ready(or4), .out_sum(s4), .out_flags(f4));

   // Reference: {N,Z,C,V,sum} from plain wide arithmetic
   function automatic logic [67:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] op, input logic cin);
      logic [63:0] mask, bp, sum;
      logic [64:0] full;
      logic        c0, n, z, c, v;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      bp   = (op[0] ? ~b : b) & mask;
      c0   = op[1] ? cin : op[0];
      full = {1'b0, a & mask} + {1'b0, bp} + {64'd0, c0};
      sum  = full[63:0] & mask;
      c    = full[w];
      n    = sum[w-1];
      z    = (sum == 64'd0);
      v    = (a[w-1] == bp[w-1]) && (sum[w-1] != a[w-1]);
      return {n, z, c, v, sum};
   endfunction

   // Drives one op into an idle pipe and measures cycles to out_valid (-1 = timeout).
   task automatic issue(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic cin,
                        output int lat, output logic [63:0] sum, output logic [3:0] fl);
      logic ov;
      lat = -1;
      sum = '0;
      fl  = '0;
      case (sel)
         0:       begin v0 = 1; a0 = a[31:0]; b0 = b[31:0]; op0 = op; ci0 = cin; end
         1:       begin v1 = 1; a1 = a[15:0]; b1 = b[15:0]; op1 = op; ci1 = cin; end
         default: begin v4 = 1; a4 = a;       b4 = b;       op4 = op; ci4 = cin; end
      endcase
      @(posedge clk); #1;
      v0 = 0; v1 = 0; v4 = 0;
      for (int c = 1; c <= 12 && lat < 0; c++) begin
         ov = (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov4;
         if (ov) begin
            lat = c;
            case (sel)
               0:       begin sum = {32'd0, s0}; fl = f0; end
               1:       begin sum = {48'd0, s1}; fl = f1; end
               default: begin sum = s4;          fl = f4; end
            endcase
         end else begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      assertions++;
      if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_valid_in_reset: got %b expected 0", ov0); end
      #3 rst_n = 1;
      @(posedge clk); #1;
      assertions++;
      if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", ov0); end
      assertions++;
      if (s0 !== 32'd0) begin failures++; $display("FAIL reset_out_sum: got %h expected 0", s0); end
      assertions++;
      if (f0 !== 4'd0) begin failures++; $display("FAIL reset_out_flags: got %b expected 0000", f0); end
      assertions++;
      if (ir0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", ir0); end
   endtask

   task automatic test_directed;
      logic [1:0]  t_op [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
      logic [31:0] t_a  [8] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'd5, 32'd5, 32'h7FFF_FFFF, 32'd5, 32'd5};
      logic [31:0] t_b  [8] = '{32'h1, 32'h1, 32'h1, 32'd3, 32'd3, 32'h1, 32'd3, 32'd3};
      logic        t_ci [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] t_s  [8] = '{32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'd1, 32'h8000_0000, 32'd8, 32'd2};
      logic [3:0]  t_f  [8] = '{4'b0110, 4'b0011, 4'b1000, 4'b0000, 4'b0010, 4'b1001, 4'b0000, 4'b0010};
      int          lat;
      logic [63:0] sum;
      logic [3:0]  fl;
      for (int i = 0; i < 8; i++) begin
         issue(0, {32'd0, t_a[i]}, {32'd0, t_b[i]}, t_op[i], t_ci[i], lat, sum, fl);
         assertions++;
         if (lat !== 2) begin failures++; $display("FAIL dir%0d_latency: got %0d expected 2", i, lat); end
         assertions++;
         if (sum[31:0] !== t_s[i]) begin failures++; $display("FAIL dir%0d_sum: got %h expected %h", i, sum[31:0], t_s[i]); end
         assertions++;
         if (fl !== t_f[i]) begin failures++; $display("FAIL dir%0d_flags: got %b expected %b", i, fl, t_f[i]); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [1:0]  t_op [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
      logic [31:0] t_a  [5] = '{32'd1, 32'h100, 32'd10, 32'hFFFF_0000, 32'hF0};
      logic [31:0] t_b  [5] = '{32'd1, 32'h200, 32'd3, 32'h0001_0000, 32'h0F};
      logic        t_ci [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] t_s  [5] = '{32'd2, 32'h300, 32'd7, 32'h0, 32'h100};
      int          got = 0;
      int          stall = 0;
      bit          saw_full = 0;
      bit          drv_to = 0;
      or0 = 0;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               bit acc = 0;
               v0 = 1; a0 = t_a[i]; b0 = t_b[i]; op0 = t_op[i]; ci0 = t_ci[i];
               for (int n = 0; n < 30 && !acc; n++) begin
                  @(negedge clk);
                  acc = ir0;
                  @(posedge clk); #1;
               end
               if (!acc) drv_to = 1;
            end
            v0 = 0;
         end
         begin
            for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
               @(negedge clk);
               if (!ir0) saw_full = 1;
               if (ov0) begin
                  assertions++;
                  if (s0 !== t_s[got]) begin
                     failures++;
                     $display("FAIL b2b_sum%0d: got %h expected %h (out_ready=%b)", got, s0, t_s[got], or0);
                  end
                  if (or0) got++;
                  else stall++;
               end
               @(posedge clk); #1;
               if (stall >= 4) or0 = 1;
            end
         end
      join
      or0 = 1;
      assertions++;
      if (drv_to) begin failures++; $display("FAIL b2b_accept_timeout: got timeout expected all accepted"); end
      assertions++;
      if (got !== 5) begin failures++; $display("FAIL b2b_count: got %0d expected 5", got); end
      assertions++;
      if (saw_full !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_drop: got %b expected 1", saw_full); end
      repeat (3) @(posedge clk);
      #1;
      assertions++;
      if (ov0 !== 1'b0) begin failures++; $display("FAIL b2b_no_duplicate: got out_valid %b expected 0", ov0); end
   endtask

   task automatic test_reset_mid;
      bit stale = 0;
      or0 = 1;
      @(posedge clk); #1;
      v0 = 1; a0 = 32'd1; b0 = 32'd2; op0 = 2'b00; ci0 = 0;
      @(posedge clk); #1;
      a0 = 32'd3; b0 = 32'd4;
      @(posedge clk); #1;
      v0 = 0;
      assertions++;
      if (ov0 !== 1'b1) begin failures++; $display("FAIL rstmid_inflight: got out_valid %b expected 1", ov0); end
      #2 rst_n = 0;
      #1;
      assertions++;
      if (ov0 !== 1'b0) begin failures++; $display("FAIL rstmid_async_clear: got out_valid %b expected 0", ov0); end
      #2 rst_n = 1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (ov0) stale = 1;
      end
      assertions++;
      if (stale !== 1'b0) begin failures++; $display("FAIL rstmid_stale_output: got %b expected 0", stale); end
      assertions++;
      if (ir0 !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready: got %b expected 1", ir0); end
   endtask

   task automatic test_sweep(input int sel, input int w, input int stg);
      logic [63:0] a, b, mask, sum;
      logic [1:0]  op;
      logic        cin;
      logic [67:0] exp;
      logic [3:0]  fl;
      int          lat;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      for (int i = 0; i < 10; i++) begin
         a   = {$urandom(), $urandom()} & mask;
         b   = {$urandom(), $urandom()} & mask;
         op  = 2'($urandom_range(0, 3));
         cin = 1'($urandom_range(0, 1));
         if (i == 0) begin a = mask; b = 64'd1; op = 2'b00; end
         if (i == 1) begin a = 64'd0; b = 64'd1; op = 2'b01; end
         exp = model(w, a, b, op, cin);
         issue(sel, a, b, op, cin, lat, sum, fl);
         assertions++;
         if (lat !== stg) begin failures++; $display("FAIL sweep_w%0d_%0d_latency: got %0d expected %0d", w, i, lat, stg); end
         assertions++;
         if (sum !== exp[63:0]) begin failures++; $display("FAIL sweep_w%0d_%0d_sum: got %h expected %h", w, i, sum, exp[63:0]); end
         assertions++;
         if (fl !== exp[67:64]) begin failures++; $display("FAIL sweep_w%0d_%0d_flags: got %b expected %b", w, i, fl, exp[67:64]); end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_sweep(1, 16, 1);
      test_sweep(4, 64, 4);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 32-bit single-cycle CLA.
- Operands are split into STAGES equal segments. Each pipeline stage resolves one segment with a BLOCK-grouped lookahead network and passes the segment carry forward.
- Adds subtract, carry-in/borrow modes, ALU flags and a valid/ready handshake with backpressure.
- Sits between the RISC-V decode/issue logic and writeback as the ALU's add/sub unit.

Parameters:
- WIDTH, 32, operand/result width; must be divisible by STAGES.
- STAGES, 2, pipeline depth and segment count; legal range 1..4; segment width SEG = WIDTH/STAGES.
- BLOCK, 4, lookahead group size inside a segment; SEG must be divisible by BLOCK.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB
- in_cin  in  1  carry-in for ADC/SBB; ignored for ADD/SUB
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  result
- out_flags  out  4  {N, Z, C, V}

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: all stage valid bits = 0; out_valid = 0; out_sum = 0; out_flags = 0; in_ready = 1 once rst_n is high.
- Operand conditioning at the input, before stage 0:
  - b' = in_b for ADD/ADC; b' = ~in_b for SUB/SBB.
  - c0 = 0 for ADD; 1 for SUB; in_cin for ADC; in_cin for SBB (in_cin=1 means no borrow).
- Stage k (k = 0..STAGES-1) computes segment k with carry c_k and registers:
  - the sum bits of segment k,
  - the carry c_{k+1},
  - the still-unprocessed upper operand segments,
  - the sign bits of a and b'.
- Within a segment: g = a&b', p = a^b'; BLOCK-bit group generate/propagate; group carries by lookahead; sum = p ^ carry.
- Latency: exactly STAGES cycles from accept (in_valid && in_ready) to out_valid, with no stalls.
- Throughput: one operation per cycle.
- Flags, formed from the full result in the final stage:
  - C = carry out of the MSB.
  - V = (a_msb == b'_msb) && (sum_msb != a_msb).
  - N = sum_msb.
  - Z = (sum == 0).
- Handshake, per stage register:
  - A stage register loads when it is empty or the stage after it is advancing.
  - The output register advances when out_ready=1.
  - in_ready = stage 0 empty OR stage 0 advancing. in_ready is combinational from out_ready when the pipe is full.
- Holding rules:
  - While out_valid=1 && out_ready=0, out_sum and out_flags hold stable.
  - Upstream stages fill any bubbles and then stall. No data is lost, duplicated or reordered.
  - An input is accepted only when in_valid && in_ready. Inputs are sampled only on accept.
- Simultaneous events: accept and retire in the same cycle on a full pipe is legal and keeps the pipe full.
- Wrap-around: the result is modulo 2^WIDTH.
- Reset mid-operation: in-flight operations are discarded and all valids cleared immediately. No result is produced after reset releases.
- STAGES=1: a single registered full-width CLA stage with latency 1.

Decomposition:
- Package cla_pkg:
  - op encodings OP_ADD/OP_SUB/OP_ADC/OP_SBB,
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cla_block: combinational SEG-bit lookahead segment, parametrised by SEG and BLOCK. Outputs the segment sum and carry out.
- Top level: STAGES instances of cla_block, the stage registers and the handshake logic.

Test Plan (WIDTH=32, STAGES=2, BLOCK=4 unless noted):
- ADD 0xFFFFFFFF + 0x00000001 -> sum 0x00000000, flags N0 Z1 C1 V0, out_valid exactly 2 cycles after accept.
- SUB 0x80000000 - 0x00000001 -> sum 0x7FFFFFFF, N0 Z0 C1 V1. SUB 0x00000000 - 0x00000001 -> sum 0xFFFFFFFF, N1 C0 V0.
- ADC 5 + 3 with in_cin=1 -> sum 9. SBB 5 - 3 with in_cin=0 -> sum 1, C1. ADD 0x7FFFFFFF + 1 -> 0x80000000, N1 V1.
- Backpressure: 5 back-to-back ops, out_ready low for 4 cycles after the first result:
  - in_ready drops once both stages and the output register are full,
  - results arrive in order with no loss or duplication,
  - out_sum is stable while stalled.
- Reset asserted mid-stream with 2 ops in flight -> out_valid = 0 immediately (asynchronous), no stale output after release, in_ready = 1.
- Sweep STAGES=1/4 and WIDTH=16/64 against random operands compared with a reference model -> all results and flags match, latency equals STAGES.
